// File: rtl/zilla_arith_pkg.sv
// Shared arithmetic package for the Zilla integer datapath.
// Holds the sequential-adder FSM state encoding and sizing helpers.
//   state_e     : IDLE / RUN / DONE encoding (2-bit)
//   nibbles()   : number of 4-bit slices in an operand of the given width
//   idx_width() : bit width of a nibble index for a given slice count
package zilla_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int nibbles(input int width);
        return width / 4;
    endfunction

    // A single-nibble operand still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cla_adder_4bit.sv
// 4-bit carry-lookahead adder slice. Purely combinational.
// Ports:
//   a_i, b_i : 4-bit addends
//   cin_i    : carry into bit 0
//   sum_o    : 4-bit sum
//   cout_o   : carry out of bit 3
module cla_adder_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Every carry is a flat sum-of-products of cin, so no carry ripples.
    assign c[0] = cin_i;
    assign c[1] = g[0] | (p[0] & cin_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin_i);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin_i);

    assign sum_o  = p ^ c[3:0];
    assign cout_o = c[4];

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Sequential WIDTH-bit add/subtract built on one 4-bit CLA slice.
// One nibble is processed per clock, LSB first; the carry between nibbles
// is held in a register so the combinational carry chain is one slice deep.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | in_ready high; a handshake latches operands and starts RUN
//   RUN   | one nibble per edge at idx; leaves after nibble N-1 is written
//   DONE  | result held on out_*, out_valid high until out_ready
//
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   in_valid / in_ready         : operand handshake
//   in_a, in_b, in_cin, in_sub  : operands, carry-in (add only), subtract
//   out_valid / out_ready       : result handshake
//   out_sum, out_cout, out_ovf  : result, carry out, signed overflow
//   busy                        : high whenever not IDLE
module cla_seq_adder_ctrl
    import zilla_arith_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int N  = nibbles(WIDTH);
    localparam int IW = idx_width(N);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    state_e           state_q;
    logic [IW-1:0]    idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_cout_q;
    logic             out_ovf_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [3:0] slice_a;
    logic [3:0] slice_b;
    logic [3:0] slice_sum;
    logic       slice_cout;

    assign slice_a = a_q[4*idx_q +: 4];
    assign slice_b = b_q[4*idx_q +: 4];

    cla_adder_4bit u_slice (
        .a_i    (slice_a),
        .b_i    (slice_b),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    // Sum register with the current nibble merged in; on the last RUN edge
    // this is the complete result and is copied to out_sum in the same edge.
    always_comb begin
        sum_d = sum_q;
        sum_d[4*idx_q +: 4] = slice_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Subtract is A + ~B + 1; the carry-in input is unused.
                        a_q     <= in_a;
                        b_q     <= in_sub ? ~in_b : in_b;
                        carry_q <= in_sub ? 1'b1 : in_cin;
                        sum_q   <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= slice_cout;
                    if (idx_q == IDX_LAST) begin
                        idx_q       <= '0;
                        out_sum_q   <= sum_d;
                        out_cout_q  <= slice_cout;
                        // Like-signed addends giving a differently-signed sum.
                        out_ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1])
                                     & (slice_sum[3] != a_q[WIDTH-1]);
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    idx_q       <= '0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE) & ~rst;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;

endmodule
